// File: rtl/cpu_lsu.sv
// Handshaked load/store unit between the core EX stage and the bus bridge.
// Optional misalignment trap: define CPU_LSU_MISALIGN_TRAP_EN.
module cpu_lsu #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              lsu_busy,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q, word_q, half_q, uns_q;
    logic [1:0]         lane_q;
    logic               req_ready_q, lsu_busy_q;
    logic               resp_valid_q, resp_err_q;
    logic [31:0]        resp_rdata_q;
    logic               bus_req_q, bus_wen_q;
    logic [ADDR_W-1:0]  bus_addr_q;
    logic [3:0]         bus_be_q;
    logic [31:0]        bus_wdata_q;

    logic               is_word_c, is_half_c, trap_c;
    logic [1:0]         lane_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [15:0]        lane_data_c;
    logic [31:0]        load_d;

    // Request decode: lane, byte enables, store replication, misalignment
    always_comb begin
        is_word_c = req_size[1];
        is_half_c = (req_size == 2'b01);
        lane_c    = req_addr[1:0];
        be_c      = 4'(4'b0001 << req_addr[1:0]);
        wdata_c   = {4{req_wdata[7:0]}};
        if (is_word_c) begin
            lane_c  = 2'b00;
            be_c    = 4'b1111;
            wdata_c = req_wdata;
        end else if (is_half_c) begin
            lane_c  = {req_addr[1], 1'b0};
            be_c    = 4'(4'b0011 << {req_addr[1], 1'b0});
            wdata_c = {2{req_wdata[15:0]}};
        end
`ifdef CPU_LSU_MISALIGN_TRAP_EN
        trap_c = (is_half_c && req_addr[0]) || (is_word_c && (req_addr[1:0] != 2'b00));
`else
        trap_c = 1'b0;
`endif
    end

    // Load lane select and extension from the captured request
    always_comb begin
        lane_data_c = 16'(bus_rdata >> {lane_q, 3'b000});
        if (word_q) begin
            load_d = bus_rdata;
        end else if (half_q) begin
            load_d = {{16{~uns_q & lane_data_c[15]}}, lane_data_c};
        end else begin
            load_d = {{24{~uns_q & lane_data_c[7]}}, lane_data_c[7:0]};
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            word_q       <= 1'b0;
            half_q       <= 1'b0;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            req_ready_q  <= 1'b1;
            lsu_busy_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            bus_req_q    <= 1'b0;
            bus_wen_q    <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        lsu_busy_q  <= 1'b1;
                        we_q        <= req_we;
                        word_q      <= is_word_c;
                        half_q      <= is_half_c;
                        uns_q       <= req_unsigned;
                        lane_q      <= lane_c;
                        if (trap_c) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= S_BUS;
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b1;
                            bus_wen_q   <= req_we;
                            bus_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus_be_q    <= be_c;
                            bus_wdata_q <= wdata_c;
                        end
                    end
                end
                S_BUS: begin
                    // Acknowledge wins over a coincident timeout
                    if (bus_ack || (cnt_q == CNT_W'(TIMEOUT_CYC))) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= ~bus_ack;
                        resp_rdata_q <= (bus_ack && !we_q) ? load_d : 32'h0;
                        bus_req_q    <= 1'b0;
                        bus_wen_q    <= 1'b0;
                        bus_be_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    req_ready_q  <= 1'b1;
                    lsu_busy_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign lsu_busy   = lsu_busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_wen    = bus_wen_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Scoreboard bench for cpu_lsu: sizes, extension, waits, timeout, misalignment, reset.
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, lsu_busy;
    logic [31:0] resp_rdata;
    logic        bus_req, bus_wen, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cpu_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .cpu_clk(clk), .cpu_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .lsu_busy(lsu_busy), .bus_req(bus_req),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rdata, input logic exp_bus,
                          input logic [3:0] exp_be, input logic [31:0] exp_baddr,
                          input logic [31:0] exp_bwdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
        int lat;
        int k;
        exp_t e;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
        req_addr = $urandom; req_wdata = $urandom;
        e.rdata = exp_rdata; e.err = exp_err;
        sb_q.push_back(e);
        lat = 1;
        if (exp_bus) begin
            check({tag, "_bus_req"}, 32'(bus_req), 32'd1);
            check({tag, "_bus_addr"}, bus_addr, exp_baddr);
            check({tag, "_bus_be"}, 32'(bus_be), 32'(exp_be));
            check({tag, "_bus_wen"}, 32'(bus_wen), 32'(we));
            check({tag, "_bus_wdata"}, bus_wdata, exp_bwdata);
        end else begin
            check({tag, "_no_bus_req"}, 32'(bus_req), 32'd0);
        end
        k = 0;
        while (resp_valid !== 1'b1 && lat < 60) begin
            bus_ack = (k == waits);
            bus_rdata = rdata;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = 32'hDEAD_0BAD;
            k++;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        check({tag, "_bus_req_after"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(lsu_busy), 32'd0);
        check("rst_resp", {resp_rdata[30:0], resp_valid | resp_err}, 32'd0);
        check("rst_bus", {bus_addr[29:0], bus_req, bus_wen}, 32'd0);
        check("rst_bus_data", bus_wdata ^ {28'd0, bus_be}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        access("lb_s", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 3, 32'h80FF_0000,
               1'b1, 4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80, 1'b0, 5);
        access("lb_u", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_0000,
               1'b1, 4'b1000, 32'h100, 32'h0, 32'h0000_0080, 1'b0, 2);
        access("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 0, 32'hDEAD_BEEF,
               1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF, 32'h0, 1'b0, 2);
        access("lh_s", 1'b0, 2'b01, 1'b0, 32'h002, 32'h0, 1, 32'h9234_5678,
               1'b1, 4'b1100, 32'h000, 32'h0, 32'hFFFF_9234, 1'b0, 3);
        access("sb", 1'b1, 2'b00, 1'b0, 32'h401, 32'h0000_00A5, 0, 32'h0,
               1'b1, 4'b0010, 32'h400, 32'hA5A5_A5A5, 32'h0, 1'b0, 2);
        access("sw", 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D, 2, 32'h0,
               1'b1, 4'b1111, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0, 4);
        access("tmo", 1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 1000, 32'h0,
               1'b1, 4'b0001, 32'h010, 32'h0, 32'h0, 1'b1, 6);
        access("ack_tmo", 1'b0, 2'b11, 1'b0, 32'h020, 32'h0, 4, 32'h1357_9BDF,
               1'b1, 4'b1111, 32'h020, 32'h0, 32'h1357_9BDF, 1'b0, 6);
`ifdef CPU_LSU_MISALIGN_TRAP_EN
        access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 0, 32'h1122_3344,
               1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        access("lh_mis", 1'b0, 2'b01, 1'b1, 32'h003, 32'h0, 0, 32'h1122_3344,
               1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, 1);
`else
        access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 1, 32'h1122_3344,
               1'b1, 4'b1111, 32'h300, 32'h0, 32'h1122_3344, 1'b0, 3);
        access("lh_mis", 1'b0, 2'b01, 1'b1, 32'h003, 32'h0, 0, 32'h8122_3344,
               1'b1, 4'b1100, 32'h000, 32'h0, 32'h0000_8122, 1'b0, 2);
`endif

        // Acks outside a transaction must be ignored
        bus_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_ack = 1'b0;
        check("idle_ack_busy", 32'(lsu_busy), 32'd0);
        check("idle_ack_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of a bus transaction
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h500;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1 req_valid = 1'b0;
        check("mid_bus_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("mid_rst_bus_req", 32'(bus_req), 32'd0);
        check("mid_rst_busy", 32'(lsu_busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_bus", bus_addr | bus_wdata | {27'd0, bus_be, bus_wen}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        bus_ack = 1'b1;
        @(posedge clk); #1 bus_ack = 1'b0;
        @(posedge clk); #1;
        check("late_ack_resp", 32'(resp_valid), 32'd0);
        check("late_ack_ready", 32'(req_ready), 32'd1);

        access("post_rst", 1'b0, 2'b00, 1'b1, 32'h601, 32'h0, 0, 32'h0000_7F00,
               1'b1, 4'b0010, 32'h600, 32'h0, 32'h0000_007F, 1'b0, 2);

        repeat (2) @(posedge clk);
        #1 check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
